// File: rtl/param_state_sequencer_if.sv
// Control/status bundle for param_state_sequencer: requests flow master->slave,
// registered state and flags flow back.
interface param_state_sequencer_if #(
  parameter int unsigned NUM_STATES = 5,
  parameter int unsigned CNT_W      = 8
);
  localparam int unsigned SW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;

  logic             i_en;
  logic             i_adv;
  logic             i_jump;
  logic [SW-1:0]    i_jump_tgt;
  logic             i_err_clr;
  logic [SW-1:0]    o_state;
  logic [CNT_W-1:0] o_dwell;
  logic             o_wrap_pulse;
  logic             o_timeout_pulse;
  logic             o_bad_jump;
  logic             o_illegal_state;
  logic             o_dwell_sat;

  modport master (
    output i_en, i_adv, i_jump, i_jump_tgt, i_err_clr,
    input  o_state, o_dwell, o_wrap_pulse, o_timeout_pulse,
           o_bad_jump, o_illegal_state, o_dwell_sat
  );

  modport slave (
    input  i_en, i_adv, i_jump, i_jump_tgt, i_err_clr,
    output o_state, o_dwell, o_wrap_pulse, o_timeout_pulse,
           o_bad_jump, o_illegal_state, o_dwell_sat
  );
endinterface

// File: rtl/param_state_sequencer.sv
// General control-path state sequencer: advance/jump with range check, per-state dwell
// counter, optional timeout return to state 0, and recovery from corrupted state encodings.
module param_state_sequencer #(
  parameter int unsigned NUM_STATES = 5,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  param_state_sequencer_if.slave  io_bus
);
  localparam int unsigned      SW         = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam logic [SW:0]      NumSt      = (SW + 1)'(NUM_STATES);
  localparam logic [SW-1:0]    LastSt     = SW'(NUM_STATES - 1);
  localparam logic [CNT_W-1:0] DwellMax   = '1;
  localparam int unsigned      TimeoutM1  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] TimeoutCmp = CNT_W'(TimeoutM1);
  localparam bit               TimeoutEn  = (TIMEOUT != 0);

  logic [SW-1:0]    r_state, w_state_d;
  logic [CNT_W-1:0] r_dwell, w_dwell_d;
  logic             r_wrap, w_wrap_d;
  logic             r_tout, w_tout_d;
  logic             r_bad, w_bad_d;
  logic             r_ill, w_ill_d;
  logic             r_sat, w_sat_d;

  logic w_illegal;
  logic w_tgt_ok;
  logic w_timeout;

  // Zero-extend by one bit so the range checks stay meaningful for power-of-two state counts.
  assign w_illegal = ({1'b0, r_state} >= NumSt);
  assign w_tgt_ok  = ({1'b0, io_bus.i_jump_tgt} < NumSt);
  assign w_timeout = TimeoutEn && (r_dwell == TimeoutCmp);

  always_comb begin
    w_state_d = r_state;
    w_dwell_d = r_dwell;
    w_wrap_d  = 1'b0;
    w_tout_d  = 1'b0;
    // Clear first so a set condition later in this block overrides err_clr.
    w_bad_d   = r_bad & ~io_bus.i_err_clr;
    w_ill_d   = r_ill & ~io_bus.i_err_clr;
    w_sat_d   = r_sat & ~io_bus.i_err_clr;

    if (w_illegal) begin
      w_state_d = '0;
      w_dwell_d = '0;
      w_ill_d   = 1'b1;
    end else if (!io_bus.i_en) begin
      w_state_d = r_state;
    end else if (w_timeout) begin
      w_state_d = '0;
      w_dwell_d = '0;
      w_tout_d  = 1'b1;
    end else if (io_bus.i_jump && w_tgt_ok) begin
      w_state_d = io_bus.i_jump_tgt;
      w_dwell_d = '0;
    end else begin
      if (io_bus.i_jump) begin
        w_bad_d = 1'b1;
      end
      if (io_bus.i_adv) begin
        w_dwell_d = '0;
        if (r_state == LastSt) begin
          w_state_d = '0;
          w_wrap_d  = 1'b1;
        end else begin
          w_state_d = r_state + 1'b1;
        end
      end else begin
        if (r_dwell != DwellMax) begin
          w_dwell_d = r_dwell + 1'b1;
        end
        if (w_dwell_d == DwellMax) begin
          w_sat_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_dwell <= '0;
      r_wrap  <= 1'b0;
      r_tout  <= 1'b0;
      r_bad   <= 1'b0;
      r_ill   <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_dwell <= w_dwell_d;
      r_wrap  <= w_wrap_d;
      r_tout  <= w_tout_d;
      r_bad   <= w_bad_d;
      r_ill   <= w_ill_d;
      r_sat   <= w_sat_d;
    end
  end

  assign io_bus.o_state         = r_state;
  assign io_bus.o_dwell         = r_dwell;
  assign io_bus.o_wrap_pulse    = r_wrap;
  assign io_bus.o_timeout_pulse = r_tout;
  assign io_bus.o_bad_jump      = r_bad;
  assign io_bus.o_illegal_state = r_ill;
  assign io_bus.o_dwell_sat     = r_sat;
endmodule

// File: tb/tb_param_state_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops and compares
// after each clock edge. Three instances cover default, TIMEOUT=4 and CNT_W=4 configurations.
module tb_param_state_sequencer;
  typedef struct packed {
    logic [2:0] state;
    logic [7:0] dwell;
    logic       wrap;
    logic       tout;
    logic       bad;
    logic       ill;
    logic       sat;
  } exp_t;

  typedef struct {
    string name;
    exp_t  v;
  } entry_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  entry_t q0[$];
  entry_t q1[$];
  entry_t q2[$];

  param_state_sequencer_if #(.NUM_STATES(5), .CNT_W(8)) if_a ();
  param_state_sequencer_if #(.NUM_STATES(5), .CNT_W(8)) if_b ();
  param_state_sequencer_if #(.NUM_STATES(5), .CNT_W(4)) if_c ();

  param_state_sequencer #(.NUM_STATES(5), .CNT_W(8), .TIMEOUT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .io_bus(if_a.slave)
  );
  param_state_sequencer #(.NUM_STATES(5), .CNT_W(8), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .io_bus(if_b.slave)
  );
  param_state_sequencer #(.NUM_STATES(5), .CNT_W(4), .TIMEOUT(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .io_bus(if_c.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input int s, input int dw, input bit w, input bit t,
                              input bit b, input bit i, input bit sa);
    exp_t e;
    e.state = 3'(s);
    e.dwell = 8'(dw);
    e.wrap  = w;
    e.tout  = t;
    e.bad   = b;
    e.ill   = i;
    e.sat   = sa;
    return e;
  endfunction

  function automatic exp_t act(input int d);
    exp_t e;
    if (d == 0) begin
      e = {if_a.o_state, if_a.o_dwell, if_a.o_wrap_pulse, if_a.o_timeout_pulse,
           if_a.o_bad_jump, if_a.o_illegal_state, if_a.o_dwell_sat};
    end else if (d == 1) begin
      e = {if_b.o_state, if_b.o_dwell, if_b.o_wrap_pulse, if_b.o_timeout_pulse,
           if_b.o_bad_jump, if_b.o_illegal_state, if_b.o_dwell_sat};
    end else begin
      e = {if_c.o_state, 4'b0000, if_c.o_dwell, if_c.o_wrap_pulse, if_c.o_timeout_pulse,
           if_c.o_bad_jump, if_c.o_illegal_state, if_c.o_dwell_sat};
    end
    return e;
  endfunction

  task automatic compare(input string name, input exp_t a, input exp_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got state=%0d dwell=%0d wrap=%0b tout=%0b bad=%0b ill=%0b sat=%0b; expected state=%0d dwell=%0d wrap=%0b tout=%0b bad=%0b ill=%0b sat=%0b",
               name, a.state, a.dwell, a.wrap, a.tout, a.bad, a.ill, a.sat,
               e.state, e.dwell, e.wrap, e.tout, e.bad, e.ill, e.sat);
    end
  endtask

  task automatic drive(input int d, input logic en, input logic adv, input logic jump,
                       input logic [2:0] tgt, input logic clr);
    if (d == 0) begin
      if_a.i_en = en; if_a.i_adv = adv; if_a.i_jump = jump;
      if_a.i_jump_tgt = tgt; if_a.i_err_clr = clr;
    end else if (d == 1) begin
      if_b.i_en = en; if_b.i_adv = adv; if_b.i_jump = jump;
      if_b.i_jump_tgt = tgt; if_b.i_err_clr = clr;
    end else begin
      if_c.i_en = en; if_c.i_adv = adv; if_c.i_jump = jump;
      if_c.i_jump_tgt = tgt; if_c.i_err_clr = clr;
    end
  endtask

  // Called at a negedge: apply inputs, queue the response expected after the next posedge.
  task automatic cyc(input int d, input string name, input logic en, input logic adv,
                     input logic jump, input logic [2:0] tgt, input logic clr, input exp_t e);
    entry_t ent;
    drive(d, en, adv, jump, tgt, clr);
    ent.name = name;
    ent.v    = e;
    if (d == 0) q0.push_back(ent);
    else if (d == 1) q1.push_back(ent);
    else q2.push_back(ent);
    @(negedge clk);
  endtask

  initial begin : monitor
    entry_t ent;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin ent = q0.pop_front(); compare(ent.name, act(0), ent.v); end
      if (q1.size() > 0) begin ent = q1.pop_front(); compare(ent.name, act(1), ent.v); end
      if (q2.size() > 0) begin ent = q2.pop_front(); compare(ent.name, act(2), ent.v); end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(0, 0, 0, 0, 3'd0, 0);
    drive(1, 0, 0, 0, 3'd0, 0);
    drive(2, 0, 0, 0, 3'd0, 0);
    @(negedge clk);
    @(negedge clk);
    compare("reset_a", act(0), mk(0, 0, 0, 0, 0, 0, 0));
    compare("reset_b", act(1), mk(0, 0, 0, 0, 0, 0, 0));
    compare("reset_c", act(2), mk(0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    // T1: advance through all states with wrap
    for (int i = 1; i <= 5; i++) begin
      cyc(0, "t1_adv", 1, 1, 0, 3'd0, 0, mk(i % 5, 0, (i == 5), 0, 0, 0, 0));
    end
    cyc(0, "t1_idle", 1, 0, 0, 3'd0, 0, mk(0, 1, 0, 0, 0, 0, 0));

    // T2: bad jump falls through to adv, err_clr, legal jumps, set-wins, clear with en=0
    cyc(0, "t2_adv1", 1, 1, 0, 3'd0, 0, mk(1, 0, 0, 0, 0, 0, 0));
    cyc(0, "t2_adv2", 1, 1, 0, 3'd0, 0, mk(2, 0, 0, 0, 0, 0, 0));
    cyc(0, "t2_badjump", 1, 1, 1, 3'd7, 0, mk(3, 0, 0, 0, 1, 0, 0));
    cyc(0, "t2_errclr", 1, 0, 0, 3'd0, 1, mk(3, 1, 0, 0, 0, 0, 0));
    cyc(0, "t2_jump1", 1, 0, 1, 3'd1, 0, mk(1, 0, 0, 0, 0, 0, 0));
    cyc(0, "t2_idle", 1, 0, 0, 3'd0, 0, mk(1, 1, 0, 0, 0, 0, 0));
    cyc(0, "t2_jump_self", 1, 0, 1, 3'd1, 0, mk(1, 0, 0, 0, 0, 0, 0));
    cyc(0, "t2_set_wins", 1, 0, 1, 3'd5, 1, mk(1, 1, 0, 0, 1, 0, 0));
    cyc(0, "t2_clr_en0", 0, 0, 0, 3'd0, 1, mk(1, 1, 0, 0, 0, 0, 0));

    // T5: freeze in last state with adv/jump pending, then a corrupted state encoding
    cyc(0, "t5_adv2", 1, 1, 0, 3'd0, 0, mk(2, 0, 0, 0, 0, 0, 0));
    cyc(0, "t5_adv3", 1, 1, 0, 3'd0, 0, mk(3, 0, 0, 0, 0, 0, 0));
    cyc(0, "t5_adv4", 1, 1, 0, 3'd0, 0, mk(4, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      cyc(0, "t5_frozen", 0, 1, 1, 3'd2, 0, mk(4, 0, 0, 0, 0, 0, 0));
    end
    force dut_a.r_state = 3'd6;
    #1;
    release dut_a.r_state;
    cyc(0, "t5_illegal", 0, 0, 0, 3'd0, 0, mk(0, 0, 0, 0, 0, 1, 0));
    cyc(0, "t5_ill_hold", 1, 0, 0, 3'd0, 0, mk(0, 1, 0, 0, 0, 1, 0));
    cyc(0, "t5_ill_clr", 1, 0, 0, 3'd0, 1, mk(0, 2, 0, 0, 0, 0, 0));

    // T6: asynchronous reset mid-dwell
    cyc(0, "t6_adv1", 1, 1, 0, 3'd0, 0, mk(1, 0, 0, 0, 0, 0, 0));
    cyc(0, "t6_adv2", 1, 1, 0, 3'd0, 0, mk(2, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 9; i++) begin
      cyc(0, "t6_dwell", 1, 0, 0, 3'd0, 0, mk(2, i, 0, 0, 0, 0, 0));
    end
    drive(0, 0, 0, 0, 3'd0, 0);
    rst_n = 1'b0;
    #1;
    compare("t6_async_reset", act(0), mk(0, 0, 0, 0, 0, 0, 0));
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    cyc(0, "t6_resume_adv", 1, 1, 0, 3'd0, 0, mk(1, 0, 0, 0, 0, 0, 0));
    cyc(0, "t6_resume_idle", 1, 0, 0, 3'd0, 0, mk(1, 1, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 3'd0, 0);

    // T3: TIMEOUT=4 overrides jump and adv
    cyc(1, "t3_adv1", 1, 1, 0, 3'd0, 0, mk(1, 0, 0, 0, 0, 0, 0));
    cyc(1, "t3_adv2", 1, 1, 0, 3'd0, 0, mk(2, 0, 0, 0, 0, 0, 0));
    cyc(1, "t3_adv3", 1, 1, 0, 3'd0, 0, mk(3, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 3; i++) begin
      cyc(1, "t3_dwell", 1, 0, 0, 3'd0, 0, mk(3, i, 0, 0, 0, 0, 0));
    end
    cyc(1, "t3_timeout_jump", 1, 0, 1, 3'd1, 0, mk(0, 0, 0, 1, 0, 0, 0));
    cyc(1, "t3_after1", 1, 0, 0, 3'd0, 0, mk(0, 1, 0, 0, 0, 0, 0));
    cyc(1, "t3_after2", 1, 0, 0, 3'd0, 0, mk(0, 2, 0, 0, 0, 0, 0));
    cyc(1, "t3_after3", 1, 0, 0, 3'd0, 0, mk(0, 3, 0, 0, 0, 0, 0));
    cyc(1, "t3_timeout_adv", 1, 1, 0, 3'd0, 0, mk(0, 0, 0, 1, 0, 0, 0));
    drive(1, 0, 0, 0, 3'd0, 0);

    // T4: CNT_W=4 dwell saturates at 15
    for (int i = 1; i <= 20; i++) begin
      cyc(2, "t4_sat", 1, 0, 0, 3'd0, 0, mk(0, (i > 15) ? 15 : i, 0, 0, 0, 0, (i >= 15)));
    end
    drive(2, 0, 0, 0, 3'd0, 0);

    @(negedge clk);
    if (q0.size() + q1.size() + q2.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0",
               q0.size() + q1.size() + q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
